// File: rtl/vx_lsu_dcache_arb.sv
// LSU-to-dcache arbiter: round-robin grant of whole multi-lane requests with
// per-lane partial issue tracking, plus a one-entry response demux register.

module vx_lsu_dcache_arb_lane (
  input  logic gvalid,
  input  logic tmask,
  input  logic sent,
  input  logic ready,
  output logic valid,
  output logic fire,
  output logic ok
);
  assign valid = gvalid & tmask & ~sent;
  assign fire  = valid & ready;
  // lane needs nothing more this cycle: accepted now, already sent, or masked off
  assign ok    = ready | sent | ~tmask;
endmodule

module vx_lsu_dcache_arb #(
  parameter int NUM_REQS  = 2,
  parameter int NUM_LANES = 4,
  parameter int TAG_IN_W  = 16,
  parameter int SEL_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      req_valid,
  input  logic [NUM_REQS-1:0]                      req_rw,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]       req_tmask,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][29:0] req_addr,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][3:0]  req_byteen,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0] req_data,
  input  logic [NUM_REQS-1:0][TAG_IN_W-1:0]        req_tag,
  output logic [NUM_REQS-1:0]                      req_ready,
  output logic [NUM_LANES-1:0]                     mem_req_valid,
  input  logic [NUM_LANES-1:0]                     mem_req_ready,
  output logic [NUM_LANES-1:0]                     mem_req_rw,
  output logic [NUM_LANES-1:0][29:0]               mem_req_addr,
  output logic [NUM_LANES-1:0][3:0]                mem_req_byteen,
  output logic [NUM_LANES-1:0][31:0]               mem_req_data,
  output logic [TAG_IN_W+SEL_W-1:0]                mem_req_tag,
  input  logic                                     mem_rsp_valid,
  input  logic [NUM_LANES-1:0]                     mem_rsp_tmask,
  input  logic [NUM_LANES-1:0][31:0]               mem_rsp_data,
  input  logic [TAG_IN_W+SEL_W-1:0]                mem_rsp_tag,
  output logic                                     mem_rsp_ready,
  output logic [NUM_REQS-1:0]                      rsp_valid,
  output logic [NUM_LANES-1:0]                     rsp_tmask,
  output logic [NUM_LANES-1:0][31:0]               rsp_data,
  output logic [TAG_IN_W-1:0]                      rsp_tag,
  input  logic [NUM_REQS-1:0]                      rsp_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_n;
  logic [SEL_W-1:0]     rr_ptr, grant_q, arb_idx, grant;
  logic                 arb_valid, grant_valid, done;
  logic [NUM_LANES-1:0] sent_mask, lane_fire, lane_ok, tmask_g;

  // nearest valid requester strictly after rr_ptr, wrapping
  always_comb begin
    int d;
    int best_d;
    d         = 0;
    best_d    = NUM_REQS + 1;
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int j = 0; j < NUM_REQS; j++) begin
      d = (j > int'(rr_ptr)) ? (j - int'(rr_ptr)) : (j - int'(rr_ptr) + NUM_REQS);
      if (req_valid[j] && d < best_d) begin
        best_d    = d;
        arb_valid = 1'b1;
        arb_idx   = SEL_W'(j);
      end
    end
  end

  assign grant       = (state == LOCKED) ? grant_q : arb_idx;
  assign grant_valid = reset & ((state == LOCKED) ? req_valid[grant_q] : arb_valid);
  assign tmask_g     = req_tmask[grant];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vx_lsu_dcache_arb_lane u_lane (
      .gvalid (grant_valid),
      .tmask  (tmask_g[i]),
      .sent   (sent_mask[i]),
      .ready  (mem_req_ready[i]),
      .valid  (mem_req_valid[i]),
      .fire   (lane_fire[i]),
      .ok     (lane_ok[i])
    );
  end

  assign done           = &lane_ok;
  assign mem_req_rw     = {NUM_LANES{req_rw[grant]}};
  assign mem_req_addr   = req_addr[grant];
  assign mem_req_byteen = req_byteen[grant];
  assign mem_req_data   = req_data[grant];
  assign mem_req_tag    = {req_tag[grant], grant};

  always_comb begin
    req_ready = '0;
    if (grant_valid && done) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_n = state;
    if (grant_valid) state_n = done ? IDLE : LOCKED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sent_mask <= '0;
      grant_q   <= '0;
      rr_ptr    <= SEL_W'(NUM_REQS - 1);
    end else begin
      state <= state_n;
      if (grant_valid) begin
        if (done) begin
          sent_mask <= '0;
          rr_ptr    <= grant;
        end else if (state == IDLE) begin
          grant_q   <= grant;
          sent_mask <= lane_fire;
        end else begin
          sent_mask <= sent_mask | lane_fire;
        end
      end
    end
  end

  // response side: single holding register, steered by the tag's index bits
  logic                      out_valid, push;
  logic [SEL_W-1:0]          out_sel, rsp_sel;
  logic [(1<<SEL_W)-1:0]     sel_ok;

  assign rsp_sel = mem_rsp_tag[SEL_W-1:0];
  for (genvar k = 0; k < (1 << SEL_W); k++) begin : g_selok
    assign sel_ok[k] = (k < NUM_REQS);
  end

  assign mem_rsp_ready = ~out_valid | rsp_ready[out_sel];
  assign push          = mem_rsp_valid & mem_rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      rsp_tmask <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else if (push) begin
      out_valid <= sel_ok[rsp_sel];
      out_sel   <= rsp_sel;
      rsp_tmask <= mem_rsp_tmask;
      rsp_data  <= mem_rsp_data;
      rsp_tag   <= mem_rsp_tag[TAG_IN_W+SEL_W-1:SEL_W];
    end else if (rsp_ready[out_sel]) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REQS; k++) begin : g_rspv
    assign rsp_valid[k] = out_valid & (out_sel == SEL_W'(k));
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && push) assert (sel_ok[rsp_sel])
      else $error("dcache response index %0d out of range", rsp_sel);
  end
`endif
endmodule

// File: tb/tb_vx_lsu_dcache_arb.sv
// Directed checks of arbitration, lane locking, tag packing and response
// steering, followed by a randomized run against a transaction-level model.
module tb_vx_lsu_dcache_arb;
  localparam int NR = 2, NL = 4, TW = 16, SW = 1;

  logic                         clk, reset;
  logic [NR-1:0]                req_valid, req_rw, req_ready;
  logic [NR-1:0][NL-1:0]        req_tmask;
  logic [NR-1:0][NL-1:0][29:0]  req_addr;
  logic [NR-1:0][NL-1:0][3:0]   req_byteen;
  logic [NR-1:0][NL-1:0][31:0]  req_data;
  logic [NR-1:0][TW-1:0]        req_tag;
  logic [NL-1:0]                mem_req_valid, mem_req_ready, mem_req_rw;
  logic [NL-1:0][29:0]          mem_req_addr;
  logic [NL-1:0][3:0]           mem_req_byteen;
  logic [NL-1:0][31:0]          mem_req_data;
  logic [TW+SW-1:0]             mem_req_tag, mem_rsp_tag;
  logic                         mem_rsp_valid, mem_rsp_ready;
  logic [NL-1:0]                mem_rsp_tmask, rsp_tmask;
  logic [NL-1:0][31:0]          mem_rsp_data, rsp_data;
  logic [NR-1:0]                rsp_valid, rsp_ready;
  logic [TW-1:0]                rsp_tag;

  int total = 0, bad = 0;

  vx_lsu_dcache_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .TAG_IN_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_tmask(req_tmask), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tmask(mem_rsp_tmask),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rw = '0; req_tmask = '0; req_addr = '0; req_byteen = '0;
    req_data = '0; req_tag = '0; mem_req_ready = '0; mem_rsp_valid = 1'b0;
    mem_rsp_tmask = '0; mem_rsp_data = '0; mem_rsp_tag = '0; rsp_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic new_req(input int k);
    req_rw[k]    = 1'($urandom);
    req_tmask[k] = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
    req_tag[k]   = 16'($urandom);
    for (int l = 0; l < NL; l++) begin
      req_addr[k][l]   = 30'($urandom);
      req_byteen[k][l] = 4'($urandom);
      req_data[k][l]   = $urandom;
    end
  endtask

  // reference model state
  int           owner, rr, g;
  logic [NL-1:0] acc, need, exp_mv;
  logic [NR-1:0] exp_rr, retired, exp_rv;
  logic          hv, hsel, exp_mrr;
  logic [TW-1:0] htag;
  logic [NL-1:0] htmask;
  logic [NL-1:0][31:0] hdata;

  initial begin
    reset = 1'b0;
    idle_inputs();
    // reset state with active-looking inputs
    req_valid = 2'b11; req_tmask = {4'hF, 4'hF}; mem_req_ready = 4'hF; mem_rsp_valid = 1'b1;
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(4'b0000));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("rst_mem_rsp_ready", 128'(mem_rsp_ready), 128'(1'b1));
    @(negedge clk);
    do_reset();

    // alternation with full lanes
    req_valid = 2'b11; req_tmask = {4'hF, 4'hF}; mem_req_ready = 4'hF;
    req_tag[0] = 16'h0011; req_tag[1] = 16'h0022;
    #1;
    chk("alt0_ready", 128'(req_ready), 128'(2'b01));
    chk("alt0_mvalid", 128'(mem_req_valid), 128'(4'hF));
    chk("alt0_tag", 128'(mem_req_tag), 128'(17'h00022));
    @(negedge clk); #1;
    chk("alt1_ready", 128'(req_ready), 128'(2'b10));
    chk("alt1_tag", 128'(mem_req_tag), 128'(17'h00045));
    @(negedge clk); #1;
    chk("alt2_ready", 128'(req_ready), 128'(2'b01));

    // partial issue locks the grant
    @(negedge clk);
    do_reset();
    req_valid = 2'b11; req_tmask = {4'hF, 4'hF}; mem_req_ready = 4'b0011;
    #1;
    chk("lock0_mvalid", 128'(mem_req_valid), 128'(4'hF));
    chk("lock0_ready", 128'(req_ready), 128'(2'b00));
    @(negedge clk);
    mem_req_ready = 4'b1100;
    #1;
    chk("lock1_mvalid", 128'(mem_req_valid), 128'(4'b1100));
    chk("lock1_ready", 128'(req_ready), 128'(2'b01));
    chk("lock1_idx", 128'(mem_req_tag[0]), 128'(1'b0));
    @(negedge clk);
    mem_req_ready = 4'hF;
    #1;
    chk("lock2_ready", 128'(req_ready), 128'(2'b10));

    // tag packing and payload pass-through
    @(negedge clk);
    do_reset();
    req_valid = 2'b10; req_tmask[1] = 4'hF; req_tag[1] = 16'h00AB;
    for (int l = 0; l < NL; l++) req_addr[1][l] = 30'(32'h100 + l);
    #1;
    chk("tag_pack", 128'(mem_req_tag), 128'(17'h00157));
    chk("tag_mvalid", 128'(mem_req_valid), 128'(4'hF));
    chk("tag_addr", 128'(mem_req_addr), 128'(req_addr[1]));

    // zero tmask retires immediately
    @(negedge clk);
    do_reset();
    req_valid = 2'b10; req_tmask[1] = 4'h0;
    #1;
    chk("zmask_ready", 128'(req_ready), 128'(2'b10));
    chk("zmask_mvalid", 128'(mem_req_valid), 128'(4'h0));

    // response held while its consumer stalls
    @(negedge clk);
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_tag = 17'h00157; mem_rsp_tmask = 4'h5; mem_rsp_data[0] = 32'hCAFE;
    #1;
    chk("rsp_push_ready", 128'(mem_rsp_ready), 128'(1'b1));
    @(negedge clk);
    mem_rsp_tag = 17'h00024;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rsp_hold_valid", 128'(rsp_valid), 128'(2'b10));
      chk("rsp_hold_tag", 128'(rsp_tag), 128'(16'h00AB));
      chk("rsp_hold_ready", 128'(mem_rsp_ready), 128'(1'b0));
      if (c == 1) rsp_ready = 2'b01;
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    #1;
    chk("rsp_release_ready", 128'(mem_rsp_ready), 128'(1'b1));
    chk("rsp_data", 128'(rsp_data[0]), 128'(32'hCAFE));

    // back-to-back responses
    @(negedge clk);
    rsp_ready = 2'b11; mem_rsp_tag = 17'h00069;
    #1;
    chk("b2b0_valid", 128'(rsp_valid), 128'(2'b01));
    chk("b2b0_tag", 128'(rsp_tag), 128'(16'h0012));
    chk("b2b0_ready", 128'(mem_rsp_ready), 128'(1'b1));
    @(negedge clk);
    mem_rsp_tag = 17'h000AC;
    #1;
    chk("b2b1_valid", 128'(rsp_valid), 128'(2'b10));
    chk("b2b1_tag", 128'(rsp_tag), 128'(16'h0034));
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("b2b2_valid", 128'(rsp_valid), 128'(2'b01));
    chk("b2b2_tag", 128'(rsp_tag), 128'(16'h0056));
    @(negedge clk); #1;
    chk("b2b3_valid", 128'(rsp_valid), 128'(2'b00));

    // asynchronous reset while locked
    @(negedge clk);
    do_reset();
    req_valid = 2'b11; req_tmask = {4'hF, 4'hF}; mem_req_ready = 4'b0011;
    @(negedge clk);
    mem_req_ready = 4'b0000;
    #1;
    chk("arst_pre_mvalid", 128'(mem_req_valid), 128'(4'b1100));
    #1 reset = 1'b0;
    #1;
    chk("arst_mvalid", 128'(mem_req_valid), 128'(4'h0));
    chk("arst_ready", 128'(req_ready), 128'(2'b00));
    chk("arst_rsp_ready", 128'(mem_rsp_ready), 128'(1'b1));
    @(negedge clk);
    reset = 1'b1; mem_req_ready = 4'hF;
    #1;
    chk("arst_first", 128'(req_ready), 128'(2'b01));
    chk("arst_first_mv", 128'(mem_req_valid), 128'(4'hF));

    // randomized run against the model
    @(negedge clk);
    do_reset();
    owner = -1; rr = NR - 1; acc = '0; retired = '0; hv = 1'b0; hsel = 1'b0;
    htag = '0; htmask = '0; hdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k] || retired[k]) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          new_req(k);
        end
      end
      mem_req_ready = 4'($urandom);
      rsp_ready     = 2'($urandom);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_tag   = 17'($urandom);
      mem_rsp_tmask = 4'($urandom);
      for (int l = 0; l < NL; l++) mem_rsp_data[l] = $urandom;
      #1;

      // a request owns the dcache until every masked lane has been taken
      g = -1;
      if (owner >= 0) g = owner;
      else for (int o = 1; o <= NR; o++) if (g < 0 && req_valid[(rr + o) % NR]) g = (rr + o) % NR;
      exp_mv = '0; exp_rr = '0;
      if (g >= 0) begin
        need   = req_tmask[g] & ~acc;
        exp_mv = need;
        if ((need & ~mem_req_ready) == '0) begin
          exp_rr[g] = 1'b1; owner = -1; acc = '0; rr = g;
        end else begin
          owner = g; acc = acc | (need & mem_req_ready);
        end
      end
      chk("rnd_mvalid", 128'(mem_req_valid), 128'(exp_mv));
      chk("rnd_req_ready", 128'(req_ready), 128'(exp_rr));
      if (g >= 0) begin
        chk("rnd_tag", 128'(mem_req_tag), 128'({req_tag[g], 1'(g)}));
        chk("rnd_addr", 128'(mem_req_addr), 128'(req_addr[g]));
        chk("rnd_data", mem_req_data, req_data[g]);
        chk("rnd_byteen", 128'(mem_req_byteen), 128'(req_byteen[g]));
        chk("rnd_rw", 128'(mem_req_rw), 128'({NL{req_rw[g]}}));
      end
      retired = exp_rr;

      exp_mrr = !hv || rsp_ready[hsel];
      exp_rv  = hv ? (2'b01 << hsel) : 2'b00;
      chk("rnd_mem_rsp_ready", 128'(mem_rsp_ready), 128'(exp_mrr));
      chk("rnd_rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      if (hv) begin
        chk("rnd_rsp_tag", 128'(rsp_tag), 128'(htag));
        chk("rnd_rsp_data", rsp_data, hdata);
        chk("rnd_rsp_tmask", 128'(rsp_tmask), 128'(htmask));
      end
      if (mem_rsp_valid && exp_mrr) begin
        hv = 1'b1; hsel = mem_rsp_tag[0]; htag = mem_rsp_tag[TW:1];
        htmask = mem_rsp_tmask; hdata = mem_rsp_data;
      end else if (hv && rsp_ready[hsel]) begin
        hv = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vx_lsu_dcache_arb.md
VX_LSU_DCACHE_ARB -- requirements
Module: vx_lsu_dcache_arb

Interface
REQ-001 Parameters (name, default, meaning): NUM_REQS, 2, number of requesters; NUM_LANES, 4, dcache lanes per request; TAG_IN_W, 16, requester tag width; SEL_W, max(1, clog2(NUM_REQS)), requester-index width.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  NUM_REQS  request valid, one bit per requester.
REQ-005 req_rw, req_tmask, req_addr, req_byteen, req_data, req_tag  in  per requester: 1, NUM_LANES, NUM_LANES*30, NUM_LANES*4, NUM_LANES*32, TAG_IN_W  request payload.
REQ-006 req_ready  out  NUM_REQS  request retired; asserted only in the cycle the final lane is accepted.
REQ-007 mem_req_valid, mem_req_ready  out/in  NUM_LANES each  per-lane dcache handshake.
REQ-008 mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data  out  NUM_LANES*(1, 30, 4, 32)  per-lane payload of the granted requester.
REQ-009 mem_req_tag  out  TAG_IN_W+SEL_W  {req_tag, grant index}; the index occupies the LSBs.
REQ-010 mem_rsp_valid, mem_rsp_tmask, mem_rsp_data, mem_rsp_tag  in  1, NUM_LANES, NUM_LANES*32, TAG_IN_W+SEL_W  dcache response.
REQ-011 mem_rsp_ready  out  1  response accepted.
REQ-012 rsp_valid  out  NUM_REQS; rsp_tmask, rsp_data, rsp_tag  out  NUM_LANES, NUM_LANES*32, TAG_IN_W (shared); rsp_ready  in  NUM_REQS.

Function
REQ-013 State machine: IDLE and LOCKED.
- IDLE: the grant is the first valid requester, round-robin, searching from rr_ptr+1 upward with wrap.
- LOCKED: the grant is grant_q; arbitration is frozen.
REQ-014 Lane issue: mem_req_valid[i] = grant valid & req_tmask[grant][i] & ~sent_mask[i]; the payload is a combinational pass-through (zero latency).
REQ-015 done = &(mem_req_ready | sent_mask | ~req_tmask[grant]); done is evaluated in both states.
REQ-016 done in IDLE or LOCKED: req_ready[grant]=1 for that cycle; sent_mask<=0; rr_ptr<=grant; state<=IDLE.
REQ-017 Not done in IDLE with a valid grant: state<=LOCKED; grant_q<=grant; sent_mask<=fired lanes.
REQ-018 Not done in LOCKED: sent_mask |= lanes fired this cycle.
REQ-019 A valid request with an all-zero tmask completes in its grant cycle: req_ready=1, no mem_req_valid.
REQ-020 A requester holds its payload stable from valid until req_ready; the arbiter does not check this.
REQ-021 No valid requester in IDLE: all mem_req_valid=0, state unchanged.
REQ-022 Response path: one-entry output register.
- Load condition: mem_rsp_valid & mem_rsp_ready.
- Captured fields: sel=mem_rsp_tag[SEL_W-1:0], tmask, data, and tag with the index bits stripped.
REQ-023 rsp_valid[k] = out_valid & (out_sel==k); all other rsp_valid bits are 0.
REQ-024 mem_rsp_ready = ~out_valid | rsp_ready[out_sel]; a pop and a push in the same cycle sustain 1 response per cycle.
REQ-025 A response index >= NUM_REQS is accepted and dropped, with rsp_valid all 0; simulation asserts an error.
REQ-026 The request and response paths are independent; a full response register never stalls issue.

Reset
REQ-027 While reset=0 (asynchronous):
- state=IDLE; sent_mask=0; grant_q=0; out_valid=0.
- rr_ptr=NUM_REQS-1, so requester 0 has first priority.
REQ-028 Reset outputs: req_ready=0, mem_req_valid=0, rsp_valid=0, mem_rsp_ready=1.
REQ-029 Reset asserted mid-request discards the partial issue; already-fired lanes are not re-tracked.

Verification
REQ-030 Both requesters valid, all lanes ready, tmask=4'b1111 each → cycle 0 grants requester 0 with req_ready[0]=1; cycle 1 grants requester 1; alternation continues.
REQ-031 Requester 0, tmask=1111, mem_req_ready=0011 then 1100 → cycle 0 enters LOCKED with sent_mask=0011; cycle 1 drives mem_req_valid=1100 and req_ready[0]=1; requester 1 is not granted during the lock.
REQ-032 Requester 1 alone, req_tag=16'h00AB, NUM_REQS=2 → mem_req_tag=17'h00157.
REQ-033 mem_rsp_tag=17'h00157 with rsp_ready[1]=0 for 3 cycles → rsp_valid=2'b10 and rsp_tag=16'h00AB are held; mem_rsp_ready=0 until rsp_ready[1]=1.
REQ-034 Back-to-back responses to requesters 0 then 1 with rsp_ready=2'b11 → one response per cycle, no bubbles.
REQ-035 reset driven low during LOCKED → outputs reach reset values immediately without waiting for a clock edge; after release requester 0 wins first.
